neural_unit_sequencer: RTL and testbench

//   Control stage directly upstream of the 4-input neural unit. Accepts a valid/ready stream of
//   8-bit weights, writes them into the unit's weight bank (address 0..3), waits for the shifters
//   to settle, pulses the sum trigger, then waits for layer-done and holds the 32-bit layer

---
 rtl/neural_pkg.sv | 26 ++
 rtl/nu_watchdog.sv | 39 +++
 rtl/neural_unit_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_neural_unit_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
// Shared definitions for the neural unit sequencer.
//   - Default sizing of the weight stream, weight bank and layer result.
//   - Sequencer state encoding.
//   - addr_w(): width of a counter/address able to index n entries (never below 1 bit).
package neural_pkg;

  localparam int NUM_IN_DEF     = 4;
  localparam int WEIGHT_W_DEF   = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int SETTLE_CYC_DEF = 3;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_TRIGGER,
    ST_WAIT_DONE,
    ST_HOLD
  } state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nu_watchdog.sv
// Watchdog for the neural unit's layer-done handshake.
// Counts cycles in which the sequencer is waiting on the unit.
//   clk     in  clock, rising edge
//   reset   in  synchronous, active-low reset
//   clear   in  restart the count from zero (issued with the sum trigger)
//   enable  in  one more waiting cycle has elapsed without layer-done
//   expired out the current enabled cycle is the TIMEOUT-th one
module nu_watchdog
  import neural_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // clocked process rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Flagged one count early so the sequencer can leave on the expiring edge.
  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/neural_unit_sequencer.sv
// Control stage in front of the 4-input neural unit.
// Loads NUM_IN weights from a valid/ready stream into the unit's weight bank,
// lets the shifters settle, pulses the sum trigger, then waits for layer-done
// and holds the captured layer result until the consumer acknowledges it.
//   clk, reset                  clock; synchronous active-low reset
//   start                       begin an evaluation (IDLE only)
//   reuse_weights               with start: skip the load, keep bank contents
//   layer_sel_in                with start: 1 = activated output, 0 = raw sum
//   w_data, w_valid, w_ready    weight stream (ready only while loading)
//   nu_weight, nu_address,
//   nu_write                    registered weight-bank write port of the unit
//   nu_sum_trigger              one-cycle sum trigger to the unit
//   nu_layer_sel                layer select, held for the whole evaluation
//   nu_layer_out, nu_layer_done layer result and completion from the unit
//   result, result_valid,
//   result_ack                  held result towards the consumer
//   busy                        any state other than IDLE
//   timeout_err                 sticky watchdog flag, cleared by the next start
module neural_unit_sequencer
  import neural_pkg::*;
#(
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int WEIGHT_W   = WEIGHT_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        reuse_weights,
  input  logic                        layer_sel_in,
  input  logic [WEIGHT_W-1:0]         w_data,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic [WEIGHT_W-1:0]         nu_weight,
  output logic [addr_w(NUM_IN)-1:0]   nu_address,
  output logic                        nu_write,
  output logic                        nu_sum_trigger,
  output logic                        nu_layer_sel,
  input  logic [DATA_W-1:0]           nu_layer_out,
  input  logic                        nu_layer_done,
  output logic [DATA_W-1:0]           result,
  output logic                        result_valid,
  input  logic                        result_ack,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int AW = addr_w(NUM_IN);
  localparam int SW = addr_w(SETTLE_CYC);

  state_t        state, state_next;
  logic [AW-1:0] wcnt;
  logic [SW-1:0] scnt;

  logic accept_start;
  logic w_accept;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic timeout_hit;
  logic done_hit;

  nu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    w_ready        = 1'b0;
    nu_sum_trigger = 1'b0;
    accept_start   = 1'b0;
    w_accept       = 1'b0;
    wd_clear       = 1'b0;
    wd_enable      = 1'b0;
    timeout_hit    = 1'b0;
    done_hit       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = reuse_weights ? ST_SETTLE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_accept = 1'b1;
          // Ready drops on the same edge as the last accept.
          if (wcnt == AW'(NUM_IN - 1)) state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt == SW'(SETTLE_CYC - 1)) state_next = ST_TRIGGER;
      end
      ST_TRIGGER: begin
        nu_sum_trigger = 1'b1;
        wd_clear       = 1'b1;
        state_next     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Done is checked first so it wins over a simultaneous expiry.
        if (nu_layer_done) begin
          done_hit   = 1'b1;
          state_next = ST_HOLD;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            timeout_hit = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (result_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // NOTE: state-holding signals use non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt         <= '0;
      scnt         <= '0;
      nu_weight    <= '0;
      nu_address   <= '0;
      nu_write     <= 1'b0;
      nu_layer_sel <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      nu_write <= w_accept;
      if (w_accept) begin
        nu_weight  <= w_data;
        nu_address <= wcnt;
        wcnt       <= wcnt + AW'(1);
      end

      if (accept_start) begin
        nu_layer_sel <= layer_sel_in;
        timeout_err  <= 1'b0;
        wcnt         <= '0;
      end else if (busy && state_next == ST_IDLE) begin
        nu_layer_sel <= 1'b0;
      end

      scnt <= (state == ST_SETTLE) ? scnt + SW'(1) : '0;

      if (done_hit) begin
        result       <= nu_layer_out;
        result_valid <= 1'b1;
      end else if (state == ST_HOLD && result_ack) begin
        result_valid <= 1'b0;
      end

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neural_unit_sequencer.sv
// Self-checking bench for neural_unit_sequencer: directed evaluations with
// randomized weights, stream gaps and unit responses, checked against a
// cycle-count model of the load / settle / trigger / wait / hold sequence.
module tb_neural_unit_sequencer;
  import neural_pkg::*;

  localparam int NUM_IN     = NUM_IN_DEF;
  localparam int WEIGHT_W   = WEIGHT_W_DEF;
  localparam int DATA_W     = DATA_W_DEF;
  localparam int SETTLE_CYC = SETTLE_CYC_DEF;
  localparam int TIMEOUT    = TIMEOUT_DEF;
  localparam int NEVER      = -1;

  logic                clk;
  logic                reset;
  logic                start;
  logic                reuse_weights;
  logic                layer_sel_in;
  logic [WEIGHT_W-1:0] w_data;
  logic                w_valid;
  logic                w_ready;
  logic [WEIGHT_W-1:0] nu_weight;
  logic [1:0]          nu_address;
  logic                nu_write;
  logic                nu_sum_trigger;
  logic                nu_layer_sel;
  logic [DATA_W-1:0]   nu_layer_out;
  logic                nu_layer_done;
  logic [DATA_W-1:0]   result;
  logic                result_valid;
  logic                result_ack;
  logic                busy;
  logic                timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int         c;
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  trig_q[$];

  neural_unit_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .reuse_weights  (reuse_weights),
    .layer_sel_in   (layer_sel_in),
    .w_data         (w_data),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .nu_weight      (nu_weight),
    .nu_address     (nu_address),
    .nu_write       (nu_write),
    .nu_sum_trigger (nu_sum_trigger),
    .nu_layer_sel   (nu_layer_sel),
    .nu_layer_out   (nu_layer_out),
    .nu_layer_done  (nu_layer_done),
    .result         (result),
    .result_valid   (result_valid),
    .result_ack     (result_ack),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record the unit-side activity, stamped with the cycle number.
  always @(negedge clk) begin
    if (nu_write) trig_q.size(); // keep queue live for tools; no effect
    if (nu_write) wr_q.push_back('{c: cyc, a: nu_address, d: nu_weight});
    if (nu_sum_trigger) trig_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs the sequencer must ignore in the current state.
  task automatic drive_junk();
    nu_layer_done = 1'($urandom);
    nu_layer_out  = $urandom;
    result_ack    = 1'($urandom);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " w_ready"},        32'(w_ready),        32'd0);
    check({name, " nu_weight"},      32'(nu_weight),      32'd0);
    check({name, " nu_address"},     32'(nu_address),     32'd0);
    check({name, " nu_write"},       32'(nu_write),       32'd0);
    check({name, " nu_sum_trigger"}, 32'(nu_sum_trigger), 32'd0);
    check({name, " nu_layer_sel"},   32'(nu_layer_sel),   32'd0);
    check({name, " result"},         result,              32'd0);
    check({name, " result_valid"},   32'(result_valid),   32'd0);
    check({name, " busy"},           32'(busy),           32'd0);
    check({name, " timeout_err"},    32'(timeout_err),    32'd0);
  endtask

  // One evaluation. gap_pct < 0 alternates w_valid 1/0, otherwise it is the
  // percentage of LOAD cycles without valid. done_dly counts WAIT_DONE cycles
  // (1 = the cycle right after the trigger); NEVER lets the watchdog expire.
  task automatic run_eval(input string name, input bit reuse, input bit sel, input bit fixed,
                          input int gap_pct, input int done_dly, input logic [31:0] lo,
                          input int ack_dly);
    logic [7:0] words[$];
    int         acc_cyc[$];
    int         start_cyc;
    int         load_cycles;
    int         acc;
    int         exp_trig;
    bit         v;

    for (int i = 0; i <= NUM_IN; i++) words.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    wr_q.delete();
    trig_q.delete();

    start         = 1'b1;
    reuse_weights = reuse;
    layer_sel_in  = sel;
    w_valid       = 1'b0;
    drive_junk();
    start_cyc = cyc;
    step();
    start         = 1'b0;
    reuse_weights = 1'($urandom);
    layer_sel_in  = 1'($urandom);
    check({name, " busy after start"},  32'(busy),         32'd1);
    check({name, " layer_sel latched"}, 32'(nu_layer_sel), 32'(sel));
    check({name, " timeout cleared"},   32'(timeout_err),  32'd0);

    load_cycles = 0;
    acc         = 0;
    if (!reuse) begin
      while (acc < NUM_IN) begin
        v = (gap_pct < 0) ? (load_cycles % 2 == 0) : (int'($urandom_range(99)) >= gap_pct);
        w_valid = v;
        w_data  = words[acc];
        drive_junk();
        check({name, " w_ready in load"}, 32'(w_ready),        32'd1);
        check({name, " no early trigger"}, 32'(nu_sum_trigger), 32'd0);
        if (v) acc_cyc.push_back(cyc);
        step();
        load_cycles++;
        if (v) acc++;
      end
    end

    // A fifth word stays offered and must not be taken.
    for (int i = 0; i < SETTLE_CYC; i++) begin
      w_valid = !reuse;
      w_data  = words[NUM_IN];
      drive_junk();
      check({name, " w_ready after load"}, 32'(w_ready),        32'd0);
      check({name, " no trigger settling"}, 32'(nu_sum_trigger), 32'd0);
      step();
    end

    exp_trig = start_cyc + 1 + load_cycles + SETTLE_CYC;
    w_valid  = 1'b0;
    drive_junk();
    check({name, " trigger pulse"}, 32'(nu_sum_trigger), 32'd1);
    step();

    for (int d = 1; d <= TIMEOUT; d++) begin
      check({name, " busy waiting"},  32'(busy),         32'd1);
      check({name, " no early valid"}, 32'(result_valid), 32'd0);
      nu_layer_done = (d == done_dly);
      nu_layer_out  = (d == done_dly) ? lo : $urandom;
      result_ack    = 1'($urandom);
      start         = 1'($urandom);
      step();
      if (d == done_dly) break;
    end
    start         = 1'b0;
    nu_layer_done = 1'b0;
    result_ack    = 1'b0;

    if (done_dly >= 1 && done_dly <= TIMEOUT) begin
      for (int h = 0; h < ack_dly; h++) begin
        check({name, " result held"},       result,               lo);
        check({name, " result_valid held"}, 32'(result_valid),    32'd1);
        check({name, " busy in hold"},      32'(busy),            32'd1);
        check({name, " layer_sel held"},    32'(nu_layer_sel),    32'(sel));
        start         = 1'b1;
        nu_layer_done = 1'($urandom);
        nu_layer_out  = $urandom;
        step();
      end
      start = 1'b0;
      check({name, " result at ack"},       result,            lo);
      check({name, " result_valid at ack"}, 32'(result_valid), 32'd1);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      check({name, " valid dropped"},   32'(result_valid), 32'd0);
      check({name, " idle after ack"},  32'(busy),         32'd0);
      check({name, " layer_sel clear"}, 32'(nu_layer_sel), 32'd0);
      check({name, " no timeout"},      32'(timeout_err),  32'd0);
    end else begin
      check({name, " timeout_err set"},   32'(timeout_err),  32'd1);
      check({name, " no result_valid"},   32'(result_valid), 32'd0);
      check({name, " idle after expiry"}, 32'(busy),         32'd0);
      check({name, " layer_sel clear"},   32'(nu_layer_sel), 32'd0);
      step();
      step();
      check({name, " timeout_err sticky"}, 32'(timeout_err), 32'd1);
    end

    check({name, " trigger count"}, 32'(trig_q.size()), 32'd1);
    if (trig_q.size() > 0) check({name, " trigger cycle"}, 32'(trig_q[0]), 32'(exp_trig));
    check({name, " write count"}, 32'(wr_q.size()), reuse ? 32'd0 : 32'(NUM_IN));
    if (!reuse) begin
      for (int i = 0; i < NUM_IN && i < wr_q.size(); i++) begin
        check({name, " write addr"},  32'(wr_q[i].a), 32'(i));
        check({name, " write data"},  32'(wr_q[i].d), 32'(words[i]));
        check({name, " write cycle"}, 32'(wr_q[i].c), 32'(acc_cyc[i] + 1));
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    reuse_weights = 1'b0;
    layer_sel_in  = 1'b0;
    w_data        = '0;
    w_valid       = 1'b0;
    nu_layer_out  = '0;
    nu_layer_done = 1'b0;
    result_ack    = 1'b0;

    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();
    check_idle_outputs("after reset");

    // Back-to-back weights 1..4, done 5 cycles after trigger.
    run_eval("basic", 1'b0, 1'b0, 1'b1, 0, 5, 32'h0000_1234, 3);
    // Valid toggling 1/0 during load.
    run_eval("toggle", 1'b0, 1'b1, 1'b0, -1, 2, $urandom, 0);
    // Reused weights, activated output.
    run_eval("reuse", 1'b1, 1'b1, 1'b0, 0, 1, $urandom, 1);
    // Unit never finishes.
    run_eval("timeout", 1'b0, 1'b0, 1'b0, 30, NEVER, 32'd0, 0);
    // Next start clears the sticky flag.
    run_eval("after timeout", 1'b1, 1'b0, 1'b0, 0, 3, $urandom, 2);
    // Done on the very cycle the watchdog would expire.
    run_eval("done at limit", 1'b1, 1'b1, 1'b0, 0, TIMEOUT, 32'hDEAD_BEEF, 1);

    // Reset in the middle of a load.
    start = 1'b1;
    step();
    start   = 1'b0;
    w_valid = 1'b1;
    w_data  = 8'hA5;
    step();
    w_data = 8'h5A;
    step();
    w_valid = 1'b0;
    reset   = 1'b0;
    step();
    reset = 1'b1;
    check_idle_outputs("mid-load reset");
    run_eval("reload", 1'b0, 1'b1, 1'b0, 0, 4, $urandom, 1);

    for (int i = 0; i < 6; i++) begin
      run_eval("random", 1'($urandom), 1'($urandom), 1'b0, int'($urandom_range(60)),
               int'($urandom_range(20, 1)), $urandom, int'($urandom_range(4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
